// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// mstatus bit positions and small helpers used by the unit and its counters.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  function automatic logic [31:0] irq_cause(input logic [4:0] idx);
    return {1'b1, 31'(IRQ_BASE) + 31'(idx)};
  endfunction

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old_val | wdata;
      CSR_OP_CLEAR: return old_val & ~wdata;
      default:      return old_val;
    endcase
  endfunction

  // Counter index 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k); index 1 skips the time slot.
  function automatic logic [11:0] counter_addr(input int idx, input logic hi);
    logic [11:0] a;
    a = hi ? CSR_MCYCLEH : CSR_MCYCLE;
    if (idx != 0) a = a | 12'(idx + 1);
    return a;
  endfunction

endpackage

// File: rtl/csr_irq_perf_unit_if.sv
// CSR access bus between decode/execute (master) and the CSR unit (slave).
interface csr_irq_perf_unit_if;
  import csr_pkg::*;

  logic [11:0] csr_addr;
  csr_op_e     csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (output csr_addr, csr_op, csr_wdata, input csr_rdata, csr_illegal);
  modport slave  (input csr_addr, csr_op, csr_wdata, output csr_rdata, csr_illegal);

endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable halves; a write wins over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (en) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_irq_perf_unit.sv
// Machine-mode CSR unit: prioritised external interrupts, trap/mret sequencing and HPM counters.
// Define CSR_VECTORED_EN to enable vectored mtvec mode (mtvec[1:0] = 01).
module csr_irq_perf_unit
  import csr_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int NUM_HPM     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [31:0]                            pc,
  csr_irq_perf_unit_if.slave                     bus,
  input  logic                                   mret,
  input  logic                                   instr_retire,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic [NUM_IRQ-1:0]                     irq_in,
  output logic                                   redirect,
  output logic [31:0]                            redirect_pc
);

  localparam int          NUM_CNT      = 2 + NUM_HPM;
  localparam logic [63:0] IRQ_ONES     = (64'd1 << NUM_IRQ) - 64'd1;
  localparam logic [31:0] MIE_MASK     = 32'(IRQ_ONES << IRQ_BASE);
  localparam logic [63:0] HPM_ONES     = (64'd1 << NUM_HPM) - 64'd1;
  localparam logic [31:0] INHIBIT_MASK = 32'h5 | 32'(HPM_ONES << 3);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_pend;
  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mie_q, mtvec_q, mepc_q, mcause_q, mcountinhibit_q, mip_val;
  logic [63:0]        cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0] cnt_en, cnt_wr_lo, cnt_wr_hi;
  logic [31:0]        rd_data, wr_data;
  logic               csr_hit, csr_we;
  logic               take_irq;
  logic [4:0]         irq_idx;
  logic [31:0]        trap_cause, trap_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign mip_val = 32'(sync_q[SYNC_STAGES-1]) << IRQ_BASE;

  always_comb begin
    rd_data = '0;
    csr_hit = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        rd_data[MSTATUS_MIE]  = mstatus_mie;
        rd_data[MSTATUS_MPIE] = mstatus_mpie;
      end
      CSR_MIE:           rd_data = mie_q;
      CSR_MTVEC:         rd_data = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_data = mcountinhibit_q;
      CSR_MEPC:          rd_data = mepc_q;
      CSR_MCAUSE:        rd_data = mcause_q;
      CSR_MIP:           rd_data = mip_val;
      default:           csr_hit = 1'b0;
    endcase
    for (int c = 0; c < NUM_CNT; c++) begin
      if (bus.csr_addr == counter_addr(c, 1'b0)) begin
        rd_data = cnt_val[c][31:0];
        csr_hit = 1'b1;
      end
      if (bus.csr_addr == counter_addr(c, 1'b1)) begin
        rd_data = cnt_val[c][63:32];
        csr_hit = 1'b1;
      end
    end
  end

  // Set/clear operate on the read-back value, so WARL masking of the old value carries through.
  assign csr_we          = (bus.csr_op != CSR_OP_NONE) && csr_hit;
  assign wr_data         = csr_apply(bus.csr_op, rd_data, bus.csr_wdata);
  assign bus.csr_rdata   = rd_data;
  assign bus.csr_illegal = (bus.csr_op != CSR_OP_NONE) && !csr_hit;

  always_comb begin
    cnt_en    = '0;
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      cnt_wr_lo[c] = csr_we && (bus.csr_addr == counter_addr(c, 1'b0));
      cnt_wr_hi[c] = csr_we && (bus.csr_addr == counter_addr(c, 1'b1));
    end
    cnt_en[0] = ~mcountinhibit_q[0];
    cnt_en[1] = instr_retire & ~mcountinhibit_q[2];
    for (int k = 0; k < NUM_HPM; k++) cnt_en[2+k] = hpm_event[k] & ~mcountinhibit_q[3+k];
  end

  for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
    csr_counter64 u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en[c]),
      .wr_lo (cnt_wr_lo[c]),
      .wr_hi (cnt_wr_hi[c]),
      .wdata (wr_data),
      .value (cnt_val[c])
    );
  end

  always_comb begin
    irq_pend = sync_q[SYNC_STAGES-1] & mie_q[IRQ_BASE +: NUM_IRQ];
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = 5'(i);
    end
  end

  assign take_irq   = mstatus_mie && (|irq_pend) && !mret;
  assign trap_cause = irq_cause(irq_idx);

`ifdef CSR_VECTORED_EN
  assign trap_pc = mtvec_q[0] ? ({mtvec_q[31:2], 2'b00} + {trap_cause[29:0], 2'b00})
                              : {mtvec_q[31:2], 2'b00};
`else
  assign trap_pc = {mtvec_q[31:2], 2'b00};
`endif

  assign redirect    = take_irq | mret;
  assign redirect_pc = mret ? mepc_q : (take_irq ? trap_pc : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mcountinhibit_q <= '0;
    end else begin
      if (csr_we && bus.csr_addr == CSR_MIE) mie_q <= wr_data & MIE_MASK;
      if (csr_we && bus.csr_addr == CSR_MTVEC) begin
`ifdef CSR_VECTORED_EN
        mtvec_q <= {wr_data[31:2], 1'b0, (wr_data[1:0] == 2'b01)};
`else
        mtvec_q <= {wr_data[31:2], 2'b00};
`endif
      end
      if (csr_we && bus.csr_addr == CSR_MCOUNTINHIBIT) mcountinhibit_q <= wr_data & INHIBIT_MASK;
      // Trap entry owns mepc/mcause/mstatus; a concurrent CSR write to them is dropped.
      if (take_irq) begin
        mepc_q       <= pc & ~32'h3;
        mcause_q     <= trap_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (mret) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end else if (csr_we && bus.csr_addr == CSR_MSTATUS) begin
          mstatus_mie  <= wr_data[MSTATUS_MIE];
          mstatus_mpie <= wr_data[MSTATUS_MPIE];
        end
        if (csr_we && bus.csr_addr == CSR_MEPC)   mepc_q   <= wr_data & ~32'h3;
        if (csr_we && bus.csr_addr == CSR_MCAUSE) mcause_q <= wr_data;
      end
    end
  end

endmodule

// File: doc/csr_irq_perf_unit.md
Name: csr_irq_perf_unit

Overview:
Parametrised machine-mode CSR unit for the RV32 core. It succeeds the single-interrupt CSR block with NUM_IRQ prioritised external interrupt lines, full mstatus MIE/MPIE trap/mret sequencing, set/clear CSR ops, and NUM_HPM event counters with inhibit control. It sits beside decode/execute, supplies CSR read data and the redirect PC (trap entry or mret) to fetch, and drives the PC-select mux.

Parameters:
NUM_IRQ, 4, external interrupt lines mapped to mip/mie bits [16 +: NUM_IRQ]; legal range 1..16
NUM_HPM, 2, event counters mhpmcounter3..(3+NUM_HPM-1); legal range 0..29
SYNC_STAGES, 2, synchroniser depth on irq_in; legal range 1..3

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
pc  in  32  PC of the instruction currently in execute
csr_addr  in  12  CSR address
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
csr_wdata  in  32  write operand (rs1 or uimm)
csr_rdata  out  32  combinational read of the addressed CSR; 0 when unimplemented
csr_illegal  out  1  csr_op != 00 and csr_addr is unimplemented
mret  in  1  mret executing this cycle
instr_retire  in  1  one instruction retired this cycle
hpm_event  in  NUM_HPM  per-counter increment strobes
irq_in  in  NUM_IRQ  asynchronous level interrupt requests
redirect  out  1  fetch must load redirect_pc (trap taken or mret)
redirect_pc  out  32  trap vector or mepc

Behaviour:
- Reset values: all CSRs 0; mcountinhibit = 0 (all counters run); csr_rdata 0; redirect 0; redirect_pc 0; synchroniser flops 0.
- irq_in passes through SYNC_STAGES flops into mip[16+i] (read-only; writes ignored). mip[11] is not implemented and reads 0.
- Pending set is mip & mie. An interrupt is taken when mstatus.MIE=1, the pending set is non-zero, and mret=0. The lowest index wins. Cause = 16+i.
- Trap cycle (combinational redirect=1):
  - On the following edge: mepc<=pc, mcause<={1'b1, 31'(16+i)}, MPIE<=MIE, MIE<=0.
- mret cycle: redirect=1, redirect_pc=mepc. On the edge: MIE<=MPIE, MPIE<=1.
- mret and a pending interrupt in the same cycle: mret wins. The interrupt is taken the next cycle if MIE is re-enabled.
- A CSR write in the same cycle as a trap: the trap's updates to mepc, mcause and mstatus take priority. Writes to other CSRs still commit.
- Set/clear ops: new = old | wdata or old & ~wdata. Read returns the old value in the same cycle.
- WARL fields:
  - mstatus: only bits 3 and 7 are writable.
  - mepc[1:0]: forced to 0.
  - mie: only bits [16 +: NUM_IRQ] are writable.
- Counters (64-bit):
  - mcycle increments every cycle unless inhibit[0].
  - minstret increments on instr_retire unless inhibit[2].
  - mhpmcounter(3+k) increments on hpm_event[k] unless inhibit[3+k].
  - Low half at 0xB00/0xB02/0xB03+k; high half at 0xB80/0xB82/0xB83+k.
  - A write to either half replaces that half and suppresses the increment that cycle; the other half holds.
  - Counters wrap from 2^64-1 to 0.
- mcountinhibit is at 0x320 and is writable only in implemented bit positions.
- Implemented addresses: 0x300, 0x304, 0x305, 0x320, 0x341, 0x342, 0x344, plus the counters. All others are illegal.
- An asynchronous reset mid-trap clears everything. No pending redirect survives reset.

Optional Feature:
CSR_VECTORED_EN
- Defined: mtvec[1:0]=01 selects vectored mode, redirect_pc = {mtvec[31:2],2'b00} + 4*cause. Mode 00 is direct; modes 1x read back as 00.
- Undefined: mtvec[1:0] are hardwired to 0 and traps always go to {mtvec[31:2],2'b00}.

Decomposition:
- Package csr_pkg:
  - CSR address localparams.
  - csr_op_e enum.
  - mstatus bit indices MIE=3, MPIE=7.
  - IRQ_BASE=16.
  - Cause encoding helper.
- Sub-module csr_counter64: enable, write-low, write-high, wdata, 64-bit value. Instantiated 2+NUM_HPM times.

Test Plan:
- Direct trap: mtvec=0x100, mie[17]=1, mstatus=0x8, irq_in[1]=1 at pc 0x40 -> after SYNC_STAGES+1 cycles redirect=1, redirect_pc=0x100; next cycle mepc=0x40, mcause=0x80000011, mstatus=0x80.
- Priority: irq_in[3:0]=1010, all enabled -> cause 17 taken; mret then MIE=1 with irq still high -> cause 17 again, not 19.
- mret+irq same cycle: mstatus.MPIE=1, MIE=0, irq pending, mret=1 -> redirect_pc=mepc; next cycle the trap is taken.
- Counter wrap: write mcycleh=0xFFFFFFFF, mcycle=0xFFFFFFFE -> after 2 cycles it reads 0x0/0x0. inhibit[0]=1 -> value frozen.
- Set/clear: mie=0; op 10 wdata 0x30000 -> read 0x30000; op 11 0x10000 -> 0x20000. Illegal addr 0x7C0 -> csr_illegal=1, rdata 0.
- Vectored (CSR_VECTORED_EN): mtvec=0x201, irq 0 -> redirect_pc=0x240. Without the macro: mtvec reads 0x200 and redirect_pc=0x200.
